round_timer: RTL
================

// Module: round_timer
// PURPOSE
//   Round countdown for the two-player fight. Counts whole seconds down from
//   ROUND_SECONDS to 0 and drives time_remaining[7:0] into the VGA top level
//   (Picasso), where the timer overlay renders it.
//   Sits upstream of the renderer, beside the game FSM. Tells the game FSM
//   when the round has timed out.
// PARAMETERS
//   CLK_FREQ_HZ    50_000_000  clk cycles per second (prescaler terminal count)
//   ROUND_SECONDS  99          reload value, legal range 1..99
//   WARN_SECONDS   10          warning asserted while 0 < time_remaining <= this
// PORTS
//   clk             in   1  system clock, single clock domain
//   reset           in   1  synchronous, active-high
//   start           in   1  pulse: reload and run a new round
//   pause           in   1  level: freeze countdown while high
//   abort           in   1  pulse: stop round, return to IDLE
//   time_remaining  out  8  seconds left (binary, or BCD: see CONFIGURATION)
//   running         out  1  high in RUN state only
//   sec_tick        out  1  1-cycle pulse on every decrement
//   warning         out  1  0 < seconds <= WARN_SECONDS, in RUN or PAUSE
//   expired         out  1  1-cycle pulse on entry to DONE
//   timeout         out  1  level, high in DONE
// BEHAVIOUR
//   - Reset (sync, takes effect on next clk edge):
//     - state=IDLE, prescaler=0, seconds=ROUND_SECONDS;
//     - running/sec_tick/warning/expired/timeout all 0.
//   - States:
//     - IDLE -> RUN on start.
//     - RUN -> PAUSE when pause=1; PAUSE -> RUN when pause=0.
//     - RUN -> DONE when seconds decrements from 1 to 0.
//     - DONE holds until start or abort.
//     - Any state -> IDLE on abort.
//   - Priority each cycle: reset > start > abort > pause > tick.
//   - start from any state: seconds=ROUND_SECONDS, prescaler=0, state=RUN.
//     If pause is high on that cycle, RUN->PAUSE on the following cycle.
//   - abort: seconds=ROUND_SECONDS, prescaler=0, state=IDLE.
//   - Prescaler:
//     - width $clog2(CLK_FREQ_HZ); advances only in RUN, holds in PAUSE,
//       and is cleared in IDLE and DONE.
//     - At CLK_FREQ_HZ-1 it wraps to 0 and asserts tick. The first tick
//       comes exactly CLK_FREQ_HZ cycles after the start cycle.
//   - On tick: seconds <= seconds-1 and sec_tick=1 on the next cycle,
//     registered. If the new value is 0: state=DONE, expired=1 for one
//     cycle, timeout=1.
//   - seconds never underflows. DONE makes no further decrements.
//   - Outputs are registered, with no combinational path from an input to
//     an output. Latency from start to running=1 is 1 cycle.
//   - The elaboration check fails if ROUND_SECONDS is 0 or >99, or if
//     WARN_SECONDS >= ROUND_SECONDS.
// CONFIGURATION
//   ROUND_TIMER_BCD_EN
//     - Defined: time_remaining is packed BCD, {tens[3:0], ones[3:0]}.
//       It is kept as two digit counters: ones wraps 0->9 with a borrow
//       from tens. Example: 99 -> 8'h99, 10 -> 8'h10, 9 -> 8'h09.
//       This gives the renderer digits directly.
//     - Undefined: time_remaining is unsigned binary {1'b0, seconds[6:0]}.
//       Example: 99 -> 8'd99.
//     - warning and expired behave the same in both modes.
// TESTING  (bench uses CLK_FREQ_HZ=4, ROUND_SECONDS=12, WARN_SECONDS=3)
//   1. reset then idle 20 cycles -> time_remaining=12, running=0,
//      sec_tick never asserts.
//   2. start pulse -> running=1 next cycle. First sec_tick 4 cycles after
//      start, time_remaining=11. It reaches 0 after 48 cycles. expired is
//      high for exactly 1 cycle, timeout stays high, and running=0.
//   3. pause held 10 cycles at seconds=7 -> value stays 7, prescaler frozen.
//      After release the next tick comes after the remaining prescaler
//      count, not a full 4.
//   4. warning: 0 at 4, 1 at 3/2/1, 0 at 0 (DONE).
//   5. start while in DONE or mid-RUN at 5 -> reload to 12, prescaler
//      restarts. start with abort on the same cycle -> RUN. abort alone
//      -> IDLE, value 12.
//   6. ROUND_TIMER_BCD_EN defined, ROUND_SECONDS=12 -> outputs step
//      8'h12, 8'h11, 8'h10, 8'h09, ..., 8'h00. Digit borrow checked at
//      10->9. reset mid-run restores 8'h12 next cycle.

Source files
------------

// File: rtl/round_timer.sv
// Round countdown timer: whole seconds from ROUND_SECONDS down to 0, with pause, abort and warning.
// Define ROUND_TIMER_BCD_EN to present time_remaining as packed BCD digits instead of binary.
module round_timer #(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int ROUND_SECONDS = 99,
    parameter int WARN_SECONDS  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    output logic [7:0] time_remaining,
    output logic       running,
    output logic       sec_tick,
    output logic       warning,
    output logic       expired,
    output logic       timeout
);

    localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ_HZ - 1);
    localparam logic [7:0]    WARN_V     = 8'(WARN_SECONDS);

    generate
        if (ROUND_SECONDS < 1 || ROUND_SECONDS > 99 || WARN_SECONDS >= ROUND_SECONDS) begin : gParamCheck
            $error("round_timer: ROUND_SECONDS must be 1..99 and WARN_SECONDS below it");
        end
    endgenerate

`ifdef ROUND_TIMER_BCD_EN
    // Two digit counters packed {tens, ones}; ones borrows from tens on 0 -> 9.
    localparam logic [7:0] COUNT_RELOAD = {4'(ROUND_SECONDS / 10), 4'(ROUND_SECONDS % 10)};

    function automatic logic [7:0] countDec(input logic [7:0] c);
        if (c[3:0] == 4'd0) begin
            countDec = {c[7:4] - 4'd1, 4'd9};
        end else begin
            countDec = {c[7:4], c[3:0] - 4'd1};
        end
    endfunction

    function automatic logic [7:0] countValue(input logic [7:0] c);
        countValue = ({4'd0, c[7:4]} * 8'd10) + {4'd0, c[3:0]};
    endfunction
`else
    localparam logic [7:0] COUNT_RELOAD = 8'(ROUND_SECONDS);

    function automatic logic [7:0] countDec(input logic [7:0] c);
        countDec = c - 8'd1;
    endfunction

    function automatic logic [7:0] countValue(input logic [7:0] c);
        countValue = c;
    endfunction
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    count_q, count_d;
    logic          tick_d;
    logic          running_q, sec_tick_q, warning_q, expired_q, timeout_q;
    logic          warning_d;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        tick_d  = 1'b0;
        if (start) begin
            state_d = RUN;
            presc_d = '0;
            count_d = COUNT_RELOAD;
        end else if (abort) begin
            state_d = IDLE;
            presc_d = '0;
            count_d = COUNT_RELOAD;
        end else begin
            case (state_q)
                RUN: begin
                    // Pause outranks a tick landing on the same cycle.
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (count_q != 8'd0) begin
                            tick_d  = 1'b1;
                            count_d = countDec(count_q);
                            if (count_d == 8'd0) begin
                                state_d = DONE;
                            end
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                IDLE:    presc_d = '0;
                DONE:    presc_d = '0;
                default: state_d = IDLE;
            endcase
        end
    end

    assign warning_d = ((state_d == RUN) || (state_d == PAUSE)) &&
                       (countValue(count_d) != 8'd0) && (countValue(count_d) <= WARN_V);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            count_q    <= COUNT_RELOAD;
            running_q  <= 1'b0;
            sec_tick_q <= 1'b0;
            warning_q  <= 1'b0;
            expired_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            running_q  <= (state_d == RUN);
            sec_tick_q <= tick_d;
            warning_q  <= warning_d;
            expired_q  <= (state_d == DONE) && (state_q != DONE);
            timeout_q  <= (state_d == DONE);
        end
    end

    assign time_remaining = count_q;
    assign running        = running_q;
    assign sec_tick       = sec_tick_q;
    assign warning        = warning_q;
    assign expired        = expired_q;
    assign timeout        = timeout_q;

endmodule
